// File: rtl/wave_pkg.sv
// Shared sample-stream definitions for the generator and analyzer blocks.
package wave_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W = 12;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'd32768;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t MEASURE = 1'b1;

endpackage

// File: rtl/wave_analyzer_if.sv
// Offset-binary sample stream from the function generator.
interface wave_analyzer_if;
  import wave_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;

  modport master (
    output sample_valid,
    output sample
  );

  modport slave (
    input sample_valid,
    input sample
  );

endinterface

// File: rtl/crossing_detector.sv
// Rising midscale crossing detector with hysteresis re-arm.
module crossing_detector
  import wave_pkg::*;
#(
  parameter int HYST = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                crossing
);

  localparam logic [SAMPLE_W-1:0] ARM_LVL =
    SAMPLE_W'(int'(MIDSCALE) - HYST);

  logic armed;

  assign crossing = armed & sample_valid
                  & (sample >= MIDSCALE);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (sample_valid) begin
      if (sample < ARM_LVL)
        armed <= 1'b1;
      else if (crossing)
        armed <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Period and peak recovery from rising midscale crossings.
// Define WAVE_ANALYZER_AVG_EN for a 4-period moving average.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int MAX_PERIOD = 4095,
  parameter int HYST = 256
) (
  input  logic                clk,
  input  logic                rst,
  wave_analyzer_if.slave      src,
  output logic [CNT_W-1:0]    period_out,
  output logic [CNT_W-1:0]    period_avg,
  output logic [SAMPLE_W-1:0] max_out,
  output logic [SAMPLE_W-1:0] min_out,
  output logic [SAMPLE_W-1:0] amp_pp,
  output logic                meas_valid,
  output logic                no_signal
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_PERIOD - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] run_max;
  logic [SAMPLE_W-1:0] run_min;
  logic [SAMPLE_W-1:0] nmax;
  logic [SAMPLE_W-1:0] nmin;
  logic                crossing;
  logic                meas;
  logic                timeout;
  logic                grow;

  crossing_detector #(
    .HYST (HYST)
  ) u_det (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (src.sample_valid),
    .sample       (src.sample),
    .crossing     (crossing)
  );

  assign nmax = (src.sample > run_max) ? src.sample : run_max;
  assign nmin = (src.sample < run_min) ? src.sample : run_min;

  // crossing beats timeout when both land on the same sample
  assign meas    = crossing & (state == MEASURE);
  assign timeout = src.sample_valid & ~crossing
                 & (state == MEASURE) & (cnt == CNT_LAST);
  assign grow    = src.sample_valid & ~crossing
                 & (state == MEASURE) & ~timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      run_max    <= '0;
      run_min    <= '0;
      period_out <= '0;
      max_out    <= '0;
      min_out    <= '0;
      amp_pp     <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      meas_valid <= 1'b0;
      unique case (1'b1)
        crossing: begin
          if (meas) begin
            period_out <= cnt;
            max_out    <= nmax;
            min_out    <= nmin;
            amp_pp     <= nmax - nmin;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
          end
          state   <= MEASURE;
          cnt     <= CNT_W'(1);
          run_max <= src.sample;
          run_min <= src.sample;
        end
        timeout: begin
          state      <= IDLE;
          no_signal  <= 1'b1;
          period_out <= '0;
          amp_pp     <= '0;
        end
        grow: begin
          cnt     <= cnt + CNT_W'(1);
          run_max <= nmax;
          run_min <= nmin;
        end
        default: ;
      endcase
    end
  end

`ifdef WAVE_ANALYZER_AVG_EN
  logic [CNT_W-1:0] hist [3];
  logic [1:0]       hcnt;
  logic [CNT_W+1:0] sum;

  assign sum = (CNT_W+2)'(cnt)
             + (CNT_W+2)'(hist[0])
             + (CNT_W+2)'(hist[1])
             + (CNT_W+2)'(hist[2]);

  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      hist[0]    <= '0;
      hist[1]    <= '0;
      hist[2]    <= '0;
      hcnt       <= '0;
      period_avg <= '0;
    end else if (meas) begin
      hist[0] <= cnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (hcnt != 2'd3)
        hcnt <= hcnt + 2'd1;
      period_avg <= (hcnt == 2'd3) ? sum[CNT_W+1:2] : cnt;
    end
  end
`else
  assign period_avg = period_out;
`endif

endmodule
